// File: rtl/tmds_serializer_if.sv
// ---------------------------------------------------------------------------
// tmds_serializer_if
// Symbol-set input channel of tmds_serializer.
//
// Handshake: a symbol set moves from master to slave on a rising clock edge
// where in_valid and in_ready are both high. in_ready does not depend on
// in_valid. in_data is ignored whenever in_ready is low.
//
// Signals:
//   in_valid  master -> slave  in_data holds a symbol set
//   in_ready  slave -> master  symbol set is accepted this cycle
//   in_data   master -> slave  lane c occupies [c*WORD_W +: WORD_W]
// ---------------------------------------------------------------------------
interface tmds_serializer_if #(
    parameter int NUM_CH = 3,
    parameter int WORD_W = 10
);
    logic                       in_valid;
    logic                       in_ready;
    logic [NUM_CH*WORD_W-1:0]   in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/tmds_serializer.sv
// ---------------------------------------------------------------------------
// tmds_serializer
// Parallel-to-serial converter for NUM_CH TMDS lanes. Every N = WORD_W/BPC
// clocks one symbol set is loaded (or IDLE_WORD on underrun) and emitted
// BPC bits per clock per lane, LSB first, with no gaps between symbols.
//
// Ports:
//   clk          serial-rate clock, the only clock of the block
//   rst_n        asynchronous active-low reset
//   en           serializer enable; low forces phase and outputs to zero
//   sym          symbol-set input channel (tmds_serializer_if.slave)
//   dout         lane c at [c*BPC +: BPC], bit 0 earliest in time
//   underrun     sticky: a load slot passed without valid data
//   underrun_clr single-cycle clear of underrun (a new underrun wins)
//   clk_lane     serialized pixel-clock pattern (TMDS_SER_CLKLANE_EN only)
//
// Optional feature macro: TMDS_SER_CLKLANE_EN adds the clock lane.
// ---------------------------------------------------------------------------
module tmds_serializer #(
    parameter int                NUM_CH    = 3,
    parameter int                WORD_W    = 10,
    parameter int                BPC       = 2,
    parameter logic [WORD_W-1:0] IDLE_WORD = 10'b1101010100
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    tmds_serializer_if.slave        sym,
    output logic [NUM_CH*BPC-1:0]   dout,
    output logic                    underrun,
    input  logic                    underrun_clr
`ifdef TMDS_SER_CLKLANE_EN
    ,
    output logic [BPC-1:0]          clk_lane
`endif
);

    localparam int N    = WORD_W / BPC;
    localparam int PH_W = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WORD_W % BPC) != 0 || !(BPC == 1 || BPC == 2 || BPC == 4)) begin : g_bad_cfg
            $error("tmds_serializer: BPC must be 1, 2 or 4 and divide WORD_W");
        end
    endgenerate

    logic [PH_W-1:0]                phase;
    logic [NUM_CH-1:0][WORD_W-1:0]  sr;
    logic [NUM_CH-1:0][WORD_W-1:0]  cur_w;
    logic [NUM_CH-1:0][WORD_W-1:0]  sr_nxt;
    logic [NUM_CH*BPC-1:0]          dout_nxt;
    logic                           load;

    // rst_n is folded in so in_ready is low for the whole time reset is held.
    assign load         = rst_n && en && (phase == '0);
    assign sym.in_ready = load;

    // On a load the fresh word's low bits go straight to dout and the shift
    // register keeps the remainder, so the first bits appear one cycle after
    // acceptance and the last bits N cycles after it.
    always_comb begin
        cur_w    = sr;
        sr_nxt   = '0;
        dout_nxt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (load) begin
                cur_w[c] = sym.in_valid ? sym.in_data[c*WORD_W +: WORD_W] : IDLE_WORD;
            end
            sr_nxt[c]                = cur_w[c] >> BPC;
            dout_nxt[c*BPC +: BPC]   = cur_w[c][BPC-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= '0;
            sr       <= '0;
            dout     <= '0;
            underrun <= 1'b0;
        end else if (!en) begin
            // Any partial symbol is dropped; the next enable starts a fresh load.
            phase <= '0;
            sr    <= '0;
            dout  <= '0;
            if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end else begin
            phase <= (phase == PH_W'(N - 1)) ? '0 : phase + 1'b1;
            sr    <= sr_nxt;
            dout  <= dout_nxt;
            if (load && !sym.in_valid) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

`ifdef TMDS_SER_CLKLANE_EN
    // Half the symbol period high then low, ones in the low (earliest) bits.
    localparam logic [WORD_W-1:0] CLK_PAT =
        {{(WORD_W - WORD_W/2){1'b0}}, {(WORD_W/2){1'b1}}};

    logic [WORD_W-1:0] clk_sr;
    logic [WORD_W-1:0] clk_cur;

    assign clk_cur = load ? CLK_PAT : clk_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sr   <= '0;
            clk_lane <= '0;
        end else if (!en) begin
            clk_sr   <= '0;
            clk_lane <= '0;
        end else begin
            clk_sr   <= clk_cur >> BPC;
            clk_lane <= clk_cur[BPC-1:0];
        end
    end
`endif

endmodule
